// File: rtl/timekeeper_controller_if.sv
// Front-panel bus of the timekeeper: tick and button pulses in, time/alarm/mode status out.
// The master drives the inputs; the controller sits on the slave side.
interface timekeeper_controller_if;
    logic       tick;
    logic       btn_mode;
    logic       btn_left;
    logic       btn_right;
    logic       btn_up;
    logic       btn_down;
    logic       alarm_en;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [5:0] alarm_min;
    logic [4:0] alarm_hour;
    logic [2:0] state;
    logic       adjusting;
    logic       alarm_ring;

    modport master (
        output tick, btn_mode, btn_left, btn_right, btn_up, btn_down, alarm_en,
        input  sec, min, hour, alarm_min, alarm_hour, state, adjusting, alarm_ring
    );

    modport slave (
        input  tick, btn_mode, btn_left, btn_right, btn_up, btn_down, alarm_en,
        output sec, min, hour, alarm_min, alarm_hour, state, adjusting, alarm_ring
    );
endinterface

// File: rtl/timekeeper_controller.sv
// 24-hour clock with settable alarm: 1 Hz sec/min/hour chain plus a mode FSM
// that lets the front-panel buttons select and adjust clock and alarm fields.
module timekeeper_controller #(
    parameter int unsigned SEC_MOD  = 60,
    parameter int unsigned MIN_MOD  = 60,
    parameter int unsigned HOUR_MOD = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    timekeeper_controller_if.slave tk
);

    typedef enum logic [2:0] {
        RUN          = 3'd0,
        ADJ_CLK_MIN  = 3'd1,
        ADJ_CLK_HOUR = 3'd2,
        ADJ_ALM_MIN  = 3'd3,
        ADJ_ALM_HOUR = 3'd4
    } state_t;

    localparam logic [5:0] SEC_MAX  = 6'(SEC_MOD - 1);
    localparam logic [5:0] MIN_MAX  = 6'(MIN_MOD - 1);
    localparam logic [4:0] HOUR_MAX = 5'(HOUR_MOD - 1);

    function automatic logic [5:0] inc6(input logic [5:0] v, input logic [5:0] vmax);
        return (v == vmax) ? '0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] dec6(input logic [5:0] v, input logic [5:0] vmax);
        return (v == '0) ? vmax : v - 6'd1;
    endfunction

    function automatic logic [4:0] inc5(input logic [4:0] v, input logic [4:0] vmax);
        return (v == vmax) ? '0 : v + 5'd1;
    endfunction

    function automatic logic [4:0] dec5(input logic [4:0] v, input logic [4:0] vmax);
        return (v == '0) ? vmax : v - 5'd1;
    endfunction

    state_t     r_state;
    logic [5:0] r_sec;
    logic [5:0] r_min;
    logic [4:0] r_hour;
    logic [5:0] r_alm_min;
    logic [4:0] r_alm_hour;
    logic       r_adjusting;
    logic       r_ring;

    state_t     w_state_nxt;
    logic [5:0] w_sec_nxt;
    logic [5:0] w_min_nxt;
    logic [4:0] w_hour_nxt;
    logic [5:0] w_alm_min_nxt;
    logic [4:0] w_alm_hour_nxt;
    logic       w_adjusting_nxt;
    logic       w_ring_nxt;

    logic       w_sec_wrap;
    logic       w_min_wrap;
    logic [5:0] w_run_sec;
    logic [5:0] w_run_min;
    logic [4:0] w_run_hour;
    logic       w_alarm_hit;
    logic       w_dir_evt;
    logic       w_fwd;
    logic       w_rev;
    logic       w_val_evt;
    logic       w_val_up;

    // Time after one RUN tick; the alarm compares against this so the ring
    // rises on the same edge the matching time is loaded.
    assign w_sec_wrap  = (r_sec == SEC_MAX);
    assign w_min_wrap  = (r_min == MIN_MAX);
    assign w_run_sec   = inc6(r_sec, SEC_MAX);
    assign w_run_min   = w_sec_wrap ? inc6(r_min, MIN_MAX) : r_min;
    assign w_run_hour  = (w_sec_wrap && w_min_wrap) ? inc5(r_hour, HOUR_MAX) : r_hour;
    assign w_alarm_hit = (w_run_sec == '0) && (w_run_min == r_alm_min) &&
                         (w_run_hour == r_alm_hour);

    assign w_dir_evt = tk.btn_left | tk.btn_right;
    assign w_fwd     = tk.btn_right & ~tk.btn_left;
    assign w_rev     = tk.btn_left & ~tk.btn_right;
    assign w_val_evt = tk.btn_up ^ tk.btn_down;
    assign w_val_up  = tk.btn_up;

    always_comb begin
        w_state_nxt    = r_state;
        w_sec_nxt      = r_sec;
        w_min_nxt      = r_min;
        w_hour_nxt     = r_hour;
        w_alm_min_nxt  = r_alm_min;
        w_alm_hour_nxt = r_alm_hour;
        w_ring_nxt     = r_ring;

        case (r_state)
            RUN: begin
                if (tk.tick) begin
                    w_sec_nxt  = w_run_sec;
                    w_min_nxt  = w_run_min;
                    w_hour_nxt = w_run_hour;
                    if (tk.alarm_en && w_alarm_hit)
                        w_ring_nxt = 1'b1;
                end
                if (tk.btn_mode) begin
                    if (r_ring)
                        w_ring_nxt = 1'b0;
                    else
                        w_state_nxt = ADJ_CLK_MIN;
                end
            end
            ADJ_CLK_MIN, ADJ_CLK_HOUR, ADJ_ALM_MIN, ADJ_ALM_HOUR: begin
                // A simultaneous left+right still consumes the cycle, masking up/down.
                if (tk.btn_mode) begin
                    w_state_nxt = RUN;
                    w_sec_nxt   = '0;
                end else if (w_dir_evt) begin
                    if (w_fwd) begin
                        case (r_state)
                            ADJ_CLK_MIN:  w_state_nxt = ADJ_CLK_HOUR;
                            ADJ_CLK_HOUR: w_state_nxt = ADJ_ALM_MIN;
                            ADJ_ALM_MIN:  w_state_nxt = ADJ_ALM_HOUR;
                            default:      w_state_nxt = ADJ_CLK_MIN;
                        endcase
                    end else if (w_rev) begin
                        case (r_state)
                            ADJ_CLK_MIN:  w_state_nxt = ADJ_ALM_HOUR;
                            ADJ_CLK_HOUR: w_state_nxt = ADJ_CLK_MIN;
                            ADJ_ALM_MIN:  w_state_nxt = ADJ_CLK_HOUR;
                            default:      w_state_nxt = ADJ_ALM_MIN;
                        endcase
                    end
                end else if (w_val_evt) begin
                    case (r_state)
                        ADJ_CLK_MIN:
                            w_min_nxt = w_val_up ? inc6(r_min, MIN_MAX) : dec6(r_min, MIN_MAX);
                        ADJ_CLK_HOUR:
                            w_hour_nxt = w_val_up ? inc5(r_hour, HOUR_MAX) : dec5(r_hour, HOUR_MAX);
                        ADJ_ALM_MIN:
                            w_alm_min_nxt = w_val_up ? inc6(r_alm_min, MIN_MAX)
                                                     : dec6(r_alm_min, MIN_MAX);
                        default:
                            w_alm_hour_nxt = w_val_up ? inc5(r_alm_hour, HOUR_MAX)
                                                      : dec5(r_alm_hour, HOUR_MAX);
                    endcase
                end
            end
            default: w_state_nxt = RUN;
        endcase

        if (!tk.alarm_en)
            w_ring_nxt = 1'b0;

        w_adjusting_nxt = (w_state_nxt != RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= RUN;
            r_sec       <= '0;
            r_min       <= '0;
            r_hour      <= '0;
            r_alm_min   <= '0;
            r_alm_hour  <= '0;
            r_adjusting <= 1'b0;
            r_ring      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sec       <= w_sec_nxt;
            r_min       <= w_min_nxt;
            r_hour      <= w_hour_nxt;
            r_alm_min   <= w_alm_min_nxt;
            r_alm_hour  <= w_alm_hour_nxt;
            r_adjusting <= w_adjusting_nxt;
            r_ring      <= w_ring_nxt;
        end
    end

    assign tk.sec        = r_sec;
    assign tk.min        = r_min;
    assign tk.hour       = r_hour;
    assign tk.alarm_min  = r_alm_min;
    assign tk.alarm_hour = r_alm_hour;
    assign tk.state      = r_state;
    assign tk.adjusting  = r_adjusting;
    assign tk.alarm_ring = r_ring;

endmodule

// File: doc/timekeeper_controller.md
Name: timekeeper_controller

Overview:
- Sequences the board's modulo-N counters (seconds, minutes, hours) into a 24-hour digital clock with a user-settable alarm.
- Advances the chain on a 1 Hz enable pulse.
- Runs a mode FSM so front-panel buttons can select and adjust the clock and alarm fields.
- Sits between the debounced button and tick sources and the display multiplexer.

Parameters:
- SEC_MOD, 60, seconds modulus; sec counts 0..SEC_MOD-1.
- MIN_MOD, 60, minutes modulus; applies to both clock and alarm minutes.
- HOUR_MOD, 24, hours modulus; applies to both clock and alarm hours.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- tick  in  1  one-cycle 1 Hz enable pulse.
- btn_mode  in  1  one-cycle debounced pulse: enter/exit adjust, or silence the alarm.
- btn_left  in  1  one-cycle pulse: select previous field.
- btn_right  in  1  one-cycle pulse: select next field.
- btn_up  in  1  one-cycle pulse: increment the selected field.
- btn_down  in  1  one-cycle pulse: decrement the selected field.
- alarm_en  in  1  level switch; 1 arms the alarm.
- sec  out  6  clock seconds.
- min  out  6  clock minutes.
- hour  out  5  clock hours.
- alarm_min  out  6  alarm minutes.
- alarm_hour  out  5  alarm hours.
- state  out  3  FSM state encoding (below).
- adjusting  out  1  1 in any ADJ_* state.
- alarm_ring  out  1  alarm sounding.

Behaviour:
- Reset (reset=0, async):
  - sec=min=hour=0; alarm_min=alarm_hour=0.
  - state=RUN; alarm_ring=0; adjusting=0.
- All outputs are registered.
- FSM states and encoding:
  - RUN=0, ADJ_CLK_MIN=1, ADJ_CLK_HOUR=2, ADJ_ALM_MIN=3, ADJ_ALM_HOUR=4.
  - Codes 5..7 are illegal and return to RUN on the next edge.
- RUN:
  - tick=1 increments sec. At SEC_MOD-1, sec wraps to 0 and min increments.
  - At MIN_MOD-1, min wraps to 0 and hour increments. At HOUR_MOD-1, hour wraps to 0.
  - New time is visible the cycle after tick (latency 1).
  - Left/right/up/down are ignored.
- btn_mode in RUN:
  - If alarm_ring=1: clears alarm_ring only; state stays RUN.
  - Otherwise: next state is ADJ_CLK_MIN.
- ADJ_* states:
  - tick is ignored; the clock is frozen.
  - btn_right steps forward: ADJ_CLK_MIN -> ADJ_CLK_HOUR -> ADJ_ALM_MIN -> ADJ_ALM_HOUR -> ADJ_CLK_MIN.
  - btn_left steps in reverse order.
  - btn_up increments the selected field modulo its modulus (59 -> 0, 23 -> 0).
  - btn_down decrements the selected field modulo its modulus (0 -> 59, 0 -> 23).
  - Adjusting minutes never carries into hours.
  - btn_mode returns to RUN and clears sec to 0 on the same edge.
- Same-cycle priority:
  - btn_mode > (btn_left/btn_right) > (btn_up/btn_down).
  - Only the highest-priority active event takes effect.
  - btn_left and btn_right together: no state change.
  - btn_up and btn_down together: no value change.
- Alarm:
  - alarm_ring sets on the edge where a RUN tick produces hour==alarm_hour, min==alarm_min, sec==0 with alarm_en=1.
  - alarm_ring is asserted in the same cycle the matching time first appears.
  - Once set, it holds until btn_mode, alarm_en=0 (cleared next edge), or reset.
  - It cannot be set in ADJ_* states and is never set by adjusting values to match.
  - Entering adjust is impossible while ringing, because btn_mode clears the ring first.
- Reset mid-operation: all state clears immediately regardless of the FSM state or any pending button.
- Widths: arithmetic uses the field width. Modulus compares use the parameter minus 1; no intermediate value ever exceeds modulus-1.

Test Plan:
- Reset, then 60 ticks -> sec=0, min=1, hour=0. Continue to 23:59:59 plus 1 tick -> 00:00:00 (full wrap).
- From RUN at 10:20:35: btn_mode, btn_up x3, btn_right, btn_down x11, btn_mode -> hour=23, min=23, sec=0, state=RUN. Ticks during adjust leave the time unchanged.
- In ADJ_CLK_MIN: btn_left -> ADJ_ALM_HOUR. btn_right twice -> ADJ_CLK_HOUR. btn_up with btn_down in the same cycle -> no change. btn_mode with btn_right in the same cycle -> RUN.
- Set alarm to 07:00, alarm_en=1, clock at 06:59:59, tick -> alarm_ring=1 the same cycle as 07:00:00. Then btn_mode -> alarm_ring=0, state stays RUN. Repeat with alarm_en=0 -> alarm_ring stays 0.
- alarm_ring=1, then drop alarm_en -> alarm_ring=0 next edge.
- Assert reset=0 mid-adjust with btn_up pulsing -> all outputs 0 and state=RUN immediately. After release, the first tick gives sec=1.
